// File: rtl/psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module      : psram_qspi_responder
// Description : QSPI PSRAM device-side model. Oversamples ce/sclk/sio on clk,
//               decodes SPI/QPI commands and serves reads/writes from an
//               internal byte array with a backdoor port for preload/peek.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_qspi_responder #(
  parameter int ADDR_W    = 16,
  parameter int WAIT_FAST = 8,
  parameter int WAIT_QUAD = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psram_ce,
  input  logic              psram_sclk,
  input  logic [3:0]        sio_i,
  output logic [3:0]        sio_o,
  output logic [3:0]        sio_oe,
  output logic              qpi_mode,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata
);

  localparam int         c_depth        = 1 << ADDR_W;
  localparam logic [7:0] c_dummy_fast   = 8'(WAIT_FAST);
  localparam logic [7:0] c_dummy_fast_q = 8'(WAIT_FAST / 2);
  localparam logic [7:0] c_dummy_quad   = 8'(WAIT_QUAD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_RDATA  = 3'd4,
    S_WDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  // Pin synchronizers and edge history
  logic [1:0]        r_ce_sync;
  logic              r_ce_d;
  logic [2:0]        r_sclk_sync;
  logic [3:0]        r_sio_s0;
  logic [3:0]        r_sio_s1;

  // Transaction state
  state_t            r_state;
  logic [6:0]        r_sh;
  logic [7:0]        r_cnt;
  logic              r_quad;
  logic              r_is_read;
  logic [7:0]        r_dummy;
  logic              r_arm;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_tx;
  logic [2:0]        r_pos;
  logic [7:0]        r_nxt;

  logic [7:0]        r_mem [0:c_depth-1];

  logic              w_ce_hi;
  logic              w_ce_fall;
  logic              w_rise;
  logic              w_fall;
  logic [3:0]        w_sio;
  logic              w_quad_sel;
  logic [7:0]        w_byte_in;
  logic              w_byte_last;
  logic [ADDR_W-1:0] w_addr_in;
  logic              w_addr_last;
  logic [7:0]        w_cur;
  logic              w_pos_last;
  logic              w_mem_we;
  logic              w_bd_we;

  // Two-flop synchronizers; ce chain resets to "low" so a ce already held low
  // across reset is not mistaken for a new falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_sync   <= 2'b00;
      r_ce_d      <= 1'b0;
      r_sclk_sync <= 3'b000;
      r_sio_s0    <= 4'h0;
      r_sio_s1    <= 4'h0;
    end else begin
      r_ce_sync   <= {r_ce_sync[0], psram_ce};
      r_ce_d      <= r_ce_sync[1];
      r_sclk_sync <= {r_sclk_sync[1:0], psram_sclk};
      r_sio_s0    <= sio_i;
      r_sio_s1    <= r_sio_s0;
    end
  end

  // Edge detection, shift-in datapath and write-port arbitration
  always_comb begin
    w_ce_hi     = r_ce_sync[1];
    w_ce_fall   = r_ce_d & ~r_ce_sync[1];
    w_rise      = r_sclk_sync[1] & ~r_sclk_sync[2];
    w_fall      = ~r_sclk_sync[1] & r_sclk_sync[2];
    w_sio       = r_sio_s1;
    w_quad_sel  = (r_state == S_CMD) ? qpi_mode : r_quad;
    w_byte_in   = w_quad_sel ? {r_sh[3:0], w_sio} : {r_sh[6:0], w_sio[0]};
    w_byte_last = w_quad_sel ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
    // Shifting through an ADDR_W-wide register drops the upper bus address bits
    w_addr_in   = r_quad ? {r_ptr[ADDR_W-5:0], w_sio} : {r_ptr[ADDR_W-2:0], w_sio[0]};
    w_addr_last = r_quad ? (r_cnt == 8'd5) : (r_cnt == 8'd23);
    w_cur       = (r_pos == 3'd0) ? r_nxt : r_tx;
    w_pos_last  = r_quad ? (r_pos == 3'd1) : (r_pos == 3'd7);
    w_mem_we    = (r_state == S_WDATA) && w_rise && w_byte_last && !w_ce_hi;
    w_bd_we     = bd_we && w_ce_hi && !w_mem_we;
  end

  // Command FSM with registered pin outputs; ce high returns to IDLE from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sh      <= 7'h00;
      r_cnt     <= 8'h00;
      r_quad    <= 1'b0;
      r_is_read <= 1'b0;
      r_dummy   <= 8'h00;
      r_arm     <= 1'b0;
      r_ptr     <= '0;
      r_tx      <= 8'h00;
      r_pos     <= 3'd0;
      sio_o     <= 4'h0;
      sio_oe    <= 4'h0;
      qpi_mode  <= 1'b0;
    end else if (w_ce_hi) begin
      r_state <= S_IDLE;
      sio_oe  <= 4'h0;
      sio_o   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ce_fall) begin
            r_state <= S_CMD;
            r_cnt   <= 8'h00;
          end
        end
        S_CMD: begin
          if (w_rise) begin
            r_sh  <= w_byte_in[6:0];
            r_cnt <= r_cnt + 8'd1;
            if (w_byte_last) begin
              r_cnt     <= 8'h00;
              r_arm     <= 1'b0;
              r_state   <= S_IGNORE;
              r_quad    <= qpi_mode;
              r_is_read <= 1'b0;
              r_dummy   <= 8'h00;
              case (w_byte_in)
                8'h03: begin
                  r_is_read <= 1'b1;
                  r_state   <= S_ADDR;
                end
                8'h0B: begin
                  r_is_read <= 1'b1;
                  r_dummy   <= qpi_mode ? c_dummy_fast_q : c_dummy_fast;
                  r_state   <= S_ADDR;
                end
                8'hEB: begin
                  r_is_read <= 1'b1;
                  r_quad    <= 1'b1;
                  r_dummy   <= c_dummy_quad;
                  r_state   <= S_ADDR;
                end
                8'h02: r_state <= S_ADDR;
                8'h38: begin
                  r_quad  <= 1'b1;
                  r_state <= S_ADDR;
                end
                8'h35: qpi_mode <= 1'b1;
                8'hF5: qpi_mode <= 1'b0;
                8'h66: r_arm <= 1'b1;
                8'h99: if (r_arm) qpi_mode <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (w_rise) begin
            r_ptr <= w_addr_in;
            r_cnt <= r_cnt + 8'd1;
            if (w_addr_last) begin
              r_cnt <= 8'h00;
              r_pos <= 3'd0;
              if (!r_is_read)            r_state <= S_WDATA;
              else if (r_dummy == 8'h00) r_state <= S_RDATA;
              else                       r_state <= S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (w_rise) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_dummy - 8'd1) r_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          // A new byte is taken from the prefetch register at each byte boundary
          if (w_fall) begin
            sio_oe <= r_quad ? 4'b1111 : 4'b0010;
            sio_o  <= r_quad ? w_cur[7:4] : {2'b00, w_cur[7], 1'b0};
            r_tx   <= r_quad ? {w_cur[3:0], 4'h0} : {w_cur[6:0], 1'b0};
            if (r_pos == 3'd0) r_ptr <= r_ptr + 1'b1;
            r_pos  <= w_pos_last ? 3'd0 : r_pos + 3'd1;
          end
        end
        S_WDATA: begin
          if (w_rise) begin
            r_sh  <= w_byte_in[6:0];
            r_cnt <= r_cnt + 8'd1;
            if (w_byte_last) begin
              r_cnt <= 8'h00;
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        S_IGNORE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Backing array: serial writes take priority; r_nxt prefetches the next read byte
  always_ff @(posedge clk) begin
    if (w_mem_we)     r_mem[r_ptr]   <= w_byte_in;
    else if (w_bd_we) r_mem[bd_addr] <= bd_wdata;
    r_nxt <= r_mem[r_ptr];
  end

  // Backdoor read port, one clock of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bd_rdata <= 8'h00;
    else        bd_rdata <= r_mem[bd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_psram_qspi_responder
// Description : Self-checking bench for psram_qspi_responder: directed vector
//               table, hand-written corner sequences and randomized traffic
//               checked against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_qspi_responder;

  localparam int ADDR_W    = 16;
  localparam int WAIT_FAST = 8;
  localparam int WAIT_QUAD = 6;
  localparam int HALF      = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              psram_ce = 1'b1;
  logic              psram_sclk = 1'b0;
  logic [3:0]        sio_i = 4'h0;
  logic [3:0]        sio_o;
  logic [3:0]        sio_oe;
  logic              qpi_mode;
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_wdata = 8'h00;
  logic [7:0]        bd_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model_mem [0:65535];
  logic       tb_qpi = 1'b0;
  logic       tb_arm = 1'b0;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          n;
    logic [47:0] data;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [9];

  psram_qspi_responder #(
    .ADDR_W    (ADDR_W),
    .WAIT_FAST (WAIT_FAST),
    .WAIT_QUAD (WAIT_QUAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psram_ce   (psram_ce),
    .psram_sclk (psram_sclk),
    .sio_i      (sio_i),
    .sio_o      (sio_o),
    .sio_oe     (sio_oe),
    .qpi_mode   (qpi_mode),
    .bd_we      (bd_we),
    .bd_addr    (bd_addr),
    .bd_wdata   (bd_wdata),
    .bd_rdata   (bd_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic sclk_cycle(input logic [3:0] drv, output logic [3:0] so, output logic [3:0] soe);
    sio_i = drv;
    repeat (HALF) @(negedge clk);
    so  = sio_o;
    soe = sio_oe;
    psram_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    psram_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic quad);
    logic [3:0] so, soe;
    if (quad) begin
      sclk_cycle(b[7:4], so, soe);
      sclk_cycle(b[3:0], so, soe);
    end else begin
      for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, b[i]}, so, soe);
    end
  endtask

  task automatic recv_byte(input logic quad, output logic [7:0] b, output logic oe_bad);
    logic [3:0] so, soe;
    b = 8'h00;
    oe_bad = 1'b0;
    if (quad) begin
      for (int i = 0; i < 2; i++) begin
        sclk_cycle(4'h0, so, soe);
        b = {b[3:0], so};
        if (soe !== 4'b1111) oe_bad = 1'b1;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        sclk_cycle(4'h0, so, soe);
        b = {b[6:0], so[1]};
        if (soe !== 4'b0010) oe_bad = 1'b1;
      end
    end
  endtask

  task automatic ce_begin();
    psram_ce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Returns sio_oe three clocks after ce rises
  task automatic ce_end(output logic [3:0] oe_after);
    repeat (HALF) @(negedge clk);
    psram_ce = 1'b1;
    repeat (3) @(negedge clk);
    oe_after = sio_oe;
    repeat (3) @(negedge clk);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
    bd_addr = a;
    @(negedge clk);
    @(negedge clk);
    d = bd_rdata;
  endtask

  task automatic cmd_only(input logic [7:0] c);
    logic [3:0] oe;
    ce_begin();
    send_byte(c, tb_qpi);
    ce_end(oe);
    if (c == 8'h35) tb_qpi = 1'b1;
    if (c == 8'hF5) tb_qpi = 1'b0;
    if (c == 8'h99 && tb_arm) tb_qpi = 1'b0;
    tb_arm = (c == 8'h66);
  endtask

  // Full read/write transaction; data is left-aligned in the 48-bit words
  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                      input logic [47:0] wd, output logic [47:0] rd,
                      output logic oe_bad, output logic [3:0] oe_after);
    logic       quad_ad, is_rd, bad;
    int         dummy;
    logic [3:0] so, soe;
    logic [7:0] b;
    is_rd   = (cmd == 8'h03) || (cmd == 8'h0B) || (cmd == 8'hEB);
    quad_ad = tb_qpi || (cmd == 8'hEB) || (cmd == 8'h38);
    dummy   = (cmd == 8'h0B) ? (tb_qpi ? WAIT_FAST / 2 : WAIT_FAST) :
              (cmd == 8'hEB) ? WAIT_QUAD : 0;
    rd      = '0;
    oe_bad  = 1'b0;
    ce_begin();
    send_byte(cmd, tb_qpi);
    for (int i = 0; i < 3; i++) send_byte(addr[23 - 8 * i -: 8], quad_ad);
    for (int i = 0; i < dummy; i++) sclk_cycle(4'h0, so, soe);
    for (int i = 0; i < n; i++) begin
      if (is_rd) begin
        recv_byte(quad_ad, b, bad);
        rd[47 - 8 * i -: 8] = b;
        if (bad) oe_bad = 1'b1;
      end else begin
        b = wd[47 - 8 * i -: 8];
        send_byte(b, quad_ad);
        model_mem[16'(addr[15:0] + 16'(i))] = b;
      end
    end
    ce_end(oe_after);
    tb_arm = 1'b0;
  endtask

  function automatic logic [47:0] model_read(input logic [23:0] addr, input int n);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[47 - 8 * i -: 8] = model_mem[16'(addr[15:0] + 16'(i))];
    return r;
  endfunction

  initial begin
    logic [47:0] rd;
    logic        oe_bad;
    logic [3:0]  oe_after, so, soe;
    logic [7:0]  d0, d1, d2, d3, b;
    logic [7:0]  cmd;
    logic [15:0] base;
    logic [23:0] a24;
    int          n, r;
    logic        is_rd;

    tbl[0] = '{8'h03, 24'h00abcd, 5, 48'h0, 48'h1122_3344_5500};
    tbl[1] = '{8'h02, 24'h00abcd, 4, 48'hdead_beef_0000, 48'h0};
    tbl[2] = '{8'h03, 24'h00abcd, 4, 48'h0, 48'hdead_beef_0000};
    tbl[3] = '{8'h0B, 24'h00abcd, 2, 48'h0, 48'hdead_0000_0000};
    tbl[4] = '{8'hEB, 24'h00abcd, 3, 48'h0, 48'hdead_be00_0000};
    tbl[5] = '{8'h02, 24'h00ffff, 2, 48'ha55a_0000_0000, 48'h0};
    tbl[6] = '{8'h03, 24'h00ffff, 2, 48'h0, 48'ha55a_0000_0000};
    tbl[7] = '{8'h38, 24'h000020, 2, 48'h1234_0000_0000, 48'h0};
    tbl[8] = '{8'h03, 24'h000020, 2, 48'h0, 48'h1234_0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sio_o", 64'(sio_o), 64'h0);
    check("rst_sio_oe", 64'(sio_oe), 64'h0);
    check("rst_qpi", 64'(qpi_mode), 64'h0);
    check("rst_bd_rdata", 64'(bd_rdata), 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Preload a wrap-around window plus the directed block
    for (int i = 0; i < 256; i++) begin
      base = 16'hFF80 + 16'(i);
      b = 8'($urandom);
      model_mem[base] = b;
      bd_write(base, b);
    end
    for (int i = 0; i < 5; i++) begin
      b = 8'h11 * 8'(i + 1);
      model_mem[16'habcd + 16'(i)] = b;
      bd_write(16'habcd + 16'(i), b);
    end

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      xfer(tbl[i].cmd, tbl[i].addr, tbl[i].n, tbl[i].data, rd, oe_bad, oe_after);
      is_rd = (tbl[i].cmd == 8'h03) || (tbl[i].cmd == 8'h0B) || (tbl[i].cmd == 8'hEB);
      if (is_rd) begin
        check($sformatf("vec%0d_data", i), 64'(rd), 64'(tbl[i].exp));
        check($sformatf("vec%0d_oe", i), 64'(oe_bad), 64'h0);
        check($sformatf("vec%0d_oe_ce_rise", i), 64'(oe_after), 64'h0);
      end
    end

    // Backdoor view of the serial write
    bd_read(16'habcd, d0);
    bd_read(16'habce, d1);
    bd_read(16'habcf, d2);
    bd_read(16'habd0, d3);
    check("bd_after_write", 64'({d0, d1, d2, d3}), 64'hdeadbeef);

    // QPI entry and quad read
    cmd_only(8'h35);
    check("qpi_on", 64'(qpi_mode), 64'h1);
    xfer(8'hEB, 24'h00abcd, 4, 48'h0, rd, oe_bad, oe_after);
    check("qpi_eb_data", 64'(rd), 64'hdeadbeef_0000);
    check("qpi_eb_oe", 64'(oe_bad), 64'h0);
    xfer(8'h0B, 24'h00ffff, 2, 48'h0, rd, oe_bad, oe_after);
    check("qpi_0b_wrap", 64'(rd), 64'ha55a_0000_0000);

    // Reset-enable arming rules
    cmd_only(8'h99);
    check("99_unarmed", 64'(qpi_mode), 64'h1);
    cmd_only(8'h66);
    cmd_only(8'h05);
    cmd_only(8'h99);
    check("99_arm_cleared", 64'(qpi_mode), 64'h1);
    cmd_only(8'h66);
    cmd_only(8'h99);
    check("66_99_exit", 64'(qpi_mode), 64'h0);

    // Write aborted after 12 data bits
    ce_begin();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) sclk_cycle(4'h1, so, soe);
    ce_end(oe_after);
    model_mem[16'h0010] = 8'h77;
    bd_read(16'h0010, d0);
    bd_read(16'h0011, d1);
    check("abort_first_byte", 64'(d0), 64'h77);
    check("abort_second_kept", 64'(d1), 64'(model_mem[16'h0011]));

    // Backdoor write is ignored while ce is low
    ce_begin();
    bd_write(16'h0030, ~model_mem[16'h0030]);
    psram_ce = 1'b1;
    repeat (4) @(negedge clk);
    bd_read(16'h0030, d0);
    check("bd_we_ce_low", 64'(d0), 64'(model_mem[16'h0030]));

    // Randomized traffic against the reference model
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 6);
      if (r == 6) begin
        cmd_only(tb_qpi ? 8'hF5 : 8'h35);
        check($sformatf("rnd%0d_qpi", t), 64'(qpi_mode), 64'(tb_qpi));
      end else begin
        case (r)
          0:       cmd = 8'h03;
          1:       cmd = 8'h0B;
          2:       cmd = 8'hEB;
          3:       cmd = 8'h02;
          default: cmd = 8'h38;
        endcase
        base = 16'hFF80 + 16'($urandom_range(0, 199));
        a24  = {8'($urandom), base};
        n    = $urandom_range(1, 6);
        xfer(cmd, a24, n, {16'($urandom), 32'($urandom)}, rd, oe_bad, oe_after);
        is_rd = (cmd == 8'h03) || (cmd == 8'h0B) || (cmd == 8'hEB);
        if (is_rd) begin
          check($sformatf("rnd%0d_rd_%h_%h", t, cmd, a24), 64'(rd), 64'(model_read(a24, n)));
          check($sformatf("rnd%0d_oe", t), 64'(oe_bad), 64'h0);
        end
      end
    end

    // rst_n pulse in the middle of a read
    if (tb_qpi) cmd_only(8'hF5);
    ce_begin();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    recv_byte(1'b0, b, oe_bad);
    check("rst_pre_byte", 64'(b), 64'(model_mem[16'h0020]));
    sclk_cycle(4'h0, so, soe);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 64'(sio_oe), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tb_qpi = 1'b0;
    tb_arm = 1'b0;
    oe_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sclk_cycle(4'h0, so, soe);
      if (soe !== 4'h0) oe_bad = 1'b1;
    end
    check("rst_sclk_ignored", 64'(oe_bad), 64'h0);
    ce_end(oe_after);
    xfer(8'h03, 24'h000020, 2, 48'h0, rd, oe_bad, oe_after);
    check("post_rst_read", 64'(rd), 64'(model_read(24'h000020, 2)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
